data_check_fifo: RTL and testbench

- Consumer-side counterpart of the FIFO data generator: drains a standard synchronous FIFO and checks every word against the generator's pattern.
- Expected pattern: `times` passes; each pass carries `size` words with values 0,1,…,size-1, truncated to WIDTH bits.
- Uses the ap_ctrl handshake (ap_start/ap_done/ap_idle/ap_ready) and reports word and error counts plus the first mismatch.
- Sits on the read port of the FIFO whose write port the generator drives.

---
 rtl/data_check_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_data_check_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_check_fifo.sv
// rtl/data_check_fifo.sv - FIFO read-side pattern checker with ap_ctrl handshake
//
// Drains a synchronous FIFO and checks each word against the generator pattern:
// `times` passes of 0,1,...,size-1, each value truncated to WIDTH bits.
//
// Ports:
//   ap_clk, ap_rst             clock (rising edge), asynchronous active-high reset
//   size, times                job shape, sampled when a start is accepted
//   fifo_rd_en                 combinational FIFO read strobe
//   fifo_rd_data, fifo_empty   FIFO read data (valid the cycle after rd_en), empty flag
//   ap_start/ap_done/ap_idle/ap_ready   block-level control handshake
//   word_count, err_count      words checked / mismatches since last start
//   err_flag                   sticky mismatch indicator
//   first_err_index/data       position and data of the first mismatching word

module data_check_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic [31:0]      size,
    input  logic [31:0]      times,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             ap_start,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic [31:0]      word_count,
    output logic [31:0]      err_count,
    output logic             err_flag,
    output logic [31:0]      first_err_index,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      size_q, size_d;
    logic [31:0]      times_q, times_d;
    logic [31:0]      iss_idx_q, iss_idx_d;
    logic [31:0]      iss_pass_q, iss_pass_d;
    logic             iss_all_q, iss_all_d;
    logic             zero_job_q, zero_job_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      exp_q, exp_d;
    logic [31:0]      chk_pass_q, chk_pass_d;
    logic [31:0]      word_count_q, word_count_d;
    logic [31:0]      err_count_q, err_count_d;
    logic             err_flag_q, err_flag_d;
    logic [31:0]      first_err_index_q, first_err_index_d;
    logic [WIDTH-1:0] first_err_data_q, first_err_data_d;

    logic [WIDTH-1:0] exp_word;
    logic             mismatch;
    logic             last_word;
    logic             exp_wrap;

    always_comb begin
        state_d           = state_q;
        size_d            = size_q;
        times_d           = times_q;
        iss_idx_d         = iss_idx_q;
        iss_pass_d        = iss_pass_q;
        iss_all_d         = iss_all_q;
        zero_job_d        = zero_job_q;
        exp_d             = exp_q;
        chk_pass_d        = chk_pass_q;
        word_count_d      = word_count_q;
        err_count_d       = err_count_q;
        err_flag_d        = err_flag_q;
        first_err_index_d = first_err_index_q;
        first_err_data_d  = first_err_data_q;
        ap_idle           = (state_q == S_IDLE);
        ap_ready          = 1'b0;
        ap_done           = 1'b0;
        fifo_rd_en        = 1'b0;

        exp_word  = WIDTH'(exp_q);
        exp_wrap  = (exp_q == size_q - 32'd1);
        mismatch  = rd_valid_q && (fifo_rd_data != exp_word);
        last_word = rd_valid_q && exp_wrap && (chk_pass_q == times_q - 32'd1);

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    ap_ready          = 1'b1;
                    size_d            = size;
                    times_d           = times;
                    iss_idx_d         = 32'd0;
                    iss_pass_d        = 32'd0;
                    exp_d             = 32'd0;
                    chk_pass_d        = 32'd0;
                    word_count_d      = 32'd0;
                    err_count_d       = 32'd0;
                    err_flag_d        = 1'b0;
                    first_err_index_d = 32'd0;
                    first_err_data_d  = '0;
                    zero_job_d        = (size == 32'd0) || (times == 32'd0);
                    // An empty job has nothing to issue; it spends one cycle in
                    // READ so done latency stays T+N+2 with N=0.
                    iss_all_d         = (size == 32'd0) || (times == 32'd0);
                    state_d           = S_READ;
                end
            end

            S_READ: begin
                fifo_rd_en = !fifo_empty && !iss_all_q;

                // Issue side: per-pass index plus pass counter avoid a 64-bit
                // size*times product.
                if (fifo_rd_en) begin
                    if (iss_idx_q == size_q - 32'd1) begin
                        iss_idx_d = 32'd0;
                        if (iss_pass_q == times_q - 32'd1) begin
                            iss_all_d = 1'b1;
                        end else begin
                            iss_pass_d = iss_pass_q + 32'd1;
                        end
                    end else begin
                        iss_idx_d = iss_idx_q + 32'd1;
                    end
                end

                // Check side: runs on data returned one cycle after each read.
                if (rd_valid_q) begin
                    word_count_d = word_count_q + 32'd1;
                    if (exp_wrap) begin
                        exp_d      = 32'd0;
                        chk_pass_d = chk_pass_q + 32'd1;
                    end else begin
                        exp_d = exp_q + 32'd1;
                    end
                    if (mismatch) begin
                        if (err_count_q != 32'hFFFF_FFFF) begin
                            err_count_d = err_count_q + 32'd1;
                        end
                        err_flag_d = 1'b1;
                        if (!err_flag_q) begin
                            first_err_index_d = word_count_q;
                            first_err_data_d  = fifo_rd_data;
                        end
                    end
                end

                if (last_word || zero_job_q) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                ap_done = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_valid_d = fifo_rd_en;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q           <= S_IDLE;
            size_q            <= 32'd0;
            times_q           <= 32'd0;
            iss_idx_q         <= 32'd0;
            iss_pass_q        <= 32'd0;
            iss_all_q         <= 1'b0;
            zero_job_q        <= 1'b0;
            rd_valid_q        <= 1'b0;
            exp_q             <= 32'd0;
            chk_pass_q        <= 32'd0;
            word_count_q      <= 32'd0;
            err_count_q       <= 32'd0;
            err_flag_q        <= 1'b0;
            first_err_index_q <= 32'd0;
            first_err_data_q  <= '0;
        end else begin
            state_q           <= state_d;
            size_q            <= size_d;
            times_q           <= times_d;
            iss_idx_q         <= iss_idx_d;
            iss_pass_q        <= iss_pass_d;
            iss_all_q         <= iss_all_d;
            zero_job_q        <= zero_job_d;
            rd_valid_q        <= rd_valid_d;
            exp_q             <= exp_d;
            chk_pass_q        <= chk_pass_d;
            word_count_q      <= word_count_d;
            err_count_q       <= err_count_d;
            err_flag_q        <= err_flag_d;
            first_err_index_q <= first_err_index_d;
            first_err_data_q  <= first_err_data_d;
        end
    end

    assign word_count      = word_count_q;
    assign err_count       = err_count_q;
    assign err_flag        = err_flag_q;
    assign first_err_index = first_err_index_q;
    assign first_err_data  = first_err_data_q;

endmodule

// File: tb/tb_data_check_fifo.sv
// tb/tb_data_check_fifo.sv - self-checking bench for data_check_fifo

module tb_data_check_fifo;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic [31:0] size = 32'd0;
    logic [31:0] times = 32'd0;
    logic        fifo_rd_en;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        fifo_empty;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [31:0] word_count, err_count, first_err_index, first_err_data;
    logic        err_flag;

    data_check_fifo #(.WIDTH(32)) dut (
        .ap_clk          (ap_clk),
        .ap_rst          (ap_rst),
        .size            (size),
        .times           (times),
        .fifo_rd_en      (fifo_rd_en),
        .fifo_rd_data    (fifo_rd_data),
        .fifo_empty      (fifo_empty),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .word_count      (word_count),
        .err_count       (err_count),
        .err_flag        (err_flag),
        .first_err_index (first_err_index),
        .first_err_data  (first_err_data)
    );

    always #5 ap_clk = ~ap_clk;

    // FIFO model: the initial block owns wr_ptr/mem, the pop process owns rd_ptr.
    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_pulses = 0;
    int          underflows = 0;
    logic        stall = 1'b0;
    bit          stall_mode = 1'b0;

    assign fifo_empty = stall || (wr_ptr == rd_ptr);

    always @(posedge ap_clk) begin
        stall <= stall_mode ? ~stall : 1'b0;
        if (fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (fifo_empty) begin
                underflows <= underflows + 1;
            end else begin
                fifo_rd_data <= mem[rd_ptr % 64];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference results for the job currently loaded into the FIFO.
    int          m_n;
    int          m_errs;
    logic [31:0] m_first_idx;
    logic [31:0] m_first_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush();
        wr_ptr = rd_ptr;
    endtask

    // Word k of the job should equal k mod s; corrupted words become errors.
    task automatic load_words(input int s, input int t, input int bad_idx,
                              input logic [31:0] bad_val, input bit rnd);
        logic [31:0] good;
        logic [31:0] v;
        m_n = s * t;
        m_errs = 0;
        m_first_idx = 32'd0;
        m_first_data = 32'd0;
        for (int k = 0; k < m_n; k++) begin
            good = 32'(k % s);
            v = good;
            if (k == bad_idx) v = bad_val;
            else if (rnd && $urandom_range(0, 3) == 0) v = $urandom;
            if (v != good) begin
                if (m_errs == 0) begin
                    m_first_idx = 32'(k);
                    m_first_data = v;
                end
                m_errs = m_errs + 1;
            end
            push(v);
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_word_count"}, word_count, 64'(m_n));
        chk({tag, "_err_count"}, err_count, 64'(m_errs));
        chk({tag, "_err_flag"}, err_flag, 64'(m_errs != 0));
        chk({tag, "_first_idx"}, first_err_index, m_first_idx);
        chk({tag, "_first_data"}, first_err_data, m_first_data);
    endtask

    // Starts a job, scrambles size/times after accept, and waits for ap_done.
    // lat is the cycle offset of ap_done relative to the accept cycle.
    task automatic run_job(input string tag, input int s, input int t,
                           input bit stl, output int lat);
        int base;
        int k;
        base = rd_pulses;
        @(negedge ap_clk);
        size = s;
        times = t;
        ap_start = 1'b1;
        stall_mode = stl;
        #1;
        chk({tag, "_ready"}, ap_ready, 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        size = $urandom;
        times = $urandom;
        k = 1;
        while (k < 2000) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) break;
            chk({tag, "_no_ready_busy"}, ap_ready, 0);
            @(posedge ap_clk);
            k = k + 1;
        end
        lat = k;
        chk({tag, "_done_seen"}, ap_done, 1);
        chk({tag, "_rd_pulses"}, 64'(rd_pulses - base), 64'(s * t));
        stall_mode = 1'b0;
    endtask

    initial begin
        int lat;
        int rc;
        int cyc;
        int base;
        int s;
        int t;
        bit stl;

        // Reset values
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_idle_in_reset", ap_idle, 1);
        ap_rst = 1'b0;
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_ready", ap_ready, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_first_idx", first_err_index, 0);
        chk("rst_first_data", first_err_data, 0);

        // Clean 4x3 job with a never-empty FIFO
        load_words(4, 3, -1, 32'd0, 1'b0);
        run_job("clean", 4, 3, 1'b0, lat);
        chk("clean_latency", lat, 14);
        check_results("clean");
        repeat (3) @(negedge ap_clk);
        chk("clean_hold_word_count", word_count, 12);
        chk("clean_hold_idle", ap_idle, 1);

        // Sixth word corrupted
        load_words(4, 2, 5, 32'h0000_DEAD, 1'b0);
        run_job("corrupt", 4, 2, 1'b0, lat);
        chk("corrupt_latency", lat, 10);
        check_results("corrupt");
        chk("corrupt_first_idx_abs", first_err_index, 5);
        chk("corrupt_first_data_abs", first_err_data, 32'h0000_DEAD);

        // Empty flag toggling every cycle
        load_words(8, 1, -1, 32'd0, 1'b0);
        run_job("stall", 8, 1, 1'b1, lat);
        check_results("stall");

        // Zero-size job: no reads even with data available
        load_words(0, 5, -1, 32'd0, 1'b0);
        push(32'd7);
        push(32'd9);
        run_job("zero", 0, 5, 1'b0, lat);
        chk("zero_latency", lat, 2);
        check_results("zero");
        @(negedge ap_clk);
        flush();

        // ap_start held high across two back-to-back runs
        load_words(3, 2, -1, 32'd0, 1'b0);
        load_words(3, 2, -1, 32'd0, 1'b0);
        base = rd_pulses;
        @(negedge ap_clk);
        size = 3;
        times = 2;
        ap_start = 1'b1;
        #1;
        rc = 0;
        cyc = 0;
        while (cyc < 200) begin
            if (ap_ready === 1'b1) rc = rc + 1;
            if (ap_done === 1'b1) break;
            @(negedge ap_clk);
            #1;
            cyc = cyc + 1;
        end
        chk("held_done_seen", ap_done, 1);
        chk("held_ready_once", rc, 1);
        chk("held_first_latency", cyc, 8);
        @(negedge ap_clk);
        #1;
        chk("held_ready_again", ap_ready, 1);
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) break;
            cyc = cyc + 1;
        end
        chk("held2_done_seen", ap_done, 1);
        check_results("held2");
        chk("held_rd_pulses", 64'(rd_pulses - base), 12);

        // Reset in the middle of a 10-word job
        load_words(10, 1, -1, 32'd0, 1'b0);
        @(negedge ap_clk);
        size = 10;
        times = 1;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge ap_clk);
            if (word_count == 32'd3) break;
            cyc = cyc + 1;
        end
        chk("mid_reached_3", word_count, 3);
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_idle", ap_idle, 1);
        chk("mid_rst_word_count", word_count, 0);
        chk("mid_rst_err_count", err_count, 0);
        chk("mid_rst_rd_en", fifo_rd_en, 0);
        chk("mid_rst_done", ap_done, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        flush();
        load_words(10, 1, -1, 32'd0, 1'b0);
        run_job("after_rst", 10, 1, 1'b0, lat);
        chk("after_rst_latency", lat, 12);
        check_results("after_rst");

        // Randomized jobs against the reference results
        for (int i = 0; i < 8; i++) begin
            s = $urandom_range(1, 5);
            t = $urandom_range(1, 3);
            stl = 1'($urandom_range(0, 1));
            load_words(s, t, -1, 32'd0, 1'b1);
            run_job($sformatf("rnd%0d", i), s, t, stl, lat);
            if (!stl) chk($sformatf("rnd%0d_latency", i), lat, 64'(s * t + 2));
            check_results($sformatf("rnd%0d", i));
        end

        @(negedge ap_clk);
        chk("no_underflow", underflows, 0);
        chk("fifo_drained", 64'(wr_ptr - rd_ptr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
